// File: rtl/anode_scan_ctrl_if.sv
// Scan interface between the anode scan controller and the digit-select / pin stage.
// The controller takes the slave side; whoever supplies enable and consumes the anode drive takes the master side.
interface anode_scan_ctrl_if;
  logic       enable;
  logic [3:0] anode;
  logic [3:0] anodeDelay;
  logic [1:0] digitIndex;
  logic       frameTick;

  modport master (
    output enable,
    input  anode,
    input  anodeDelay,
    input  digitIndex,
    input  frameTick
  );

  modport slave (
    input  enable,
    output anode,
    output anodeDelay,
    output digitIndex,
    output frameTick
  );
endinterface

// File: rtl/anode_scan_ctrl.sv
// Four-digit seven-segment anode scanner. A blank gap separates digits so the mux and decoder settle before each anode lights.
// anodeDelay leads anode by one blank period and drives the digit multiplexer.
module anode_scan_ctrl #(
  parameter int unsigned BLANK_CYCLES = 1000,
  parameter int unsigned SHOW_CYCLES  = 99000
) (
  input  logic               clk,
  input  logic               reset,
  anode_scan_ctrl_if.slave   scan
);

  localparam int unsigned MAX_CYCLES = (BLANK_CYCLES > SHOW_CYCLES) ? BLANK_CYCLES : SHOW_CYCLES;
  localparam int unsigned CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYCLES - 1);

  localparam logic [3:0] ANODE_OFF   = 4'b1111;
  localparam logic [3:0] FIRST_DIGIT = 4'b0111;
  localparam logic [3:0] LAST_DIGIT  = 4'b1110;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_e;

  state_e           state_q,      state_d;
  logic [CNT_W-1:0] count_q,      count_d;
  logic [3:0]       anode_q,      anode_d;
  logic [3:0]       anodeDelay_q, anodeDelay_d;
  logic [1:0]       digitIndex_q, digitIndex_d;
  logic             frameTick_q,  frameTick_d;

  // Dropping enable parks the scan in a fresh blank on the same digit, so the digit is re-shown in full later.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    anode_d      = anode_q;
    anodeDelay_d = anodeDelay_q;
    digitIndex_d = digitIndex_q;
    frameTick_d  = 1'b0;

    if (!scan.enable) begin
      state_d = BLANK;
      count_d = '0;
      anode_d = ANODE_OFF;
    end else begin
      unique case (state_q)
        BLANK: begin
          if (count_q == BLANK_LAST) begin
            state_d = SHOW;
            count_d = '0;
            anode_d = anodeDelay_q;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
        SHOW: begin
          if (count_q == SHOW_LAST) begin
            state_d      = BLANK;
            count_d      = '0;
            anode_d      = ANODE_OFF;
            anodeDelay_d = {anodeDelay_q[0], anodeDelay_q[3:1]};
            digitIndex_d = digitIndex_q - 2'd1;
            frameTick_d  = (anodeDelay_q == LAST_DIGIT);
          end else begin
            count_d = count_q + 1'b1;
          end
        end
        default: begin
          state_d = BLANK;
          count_d = '0;
          anode_d = ANODE_OFF;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= BLANK;
      count_q      <= '0;
      anode_q      <= ANODE_OFF;
      anodeDelay_q <= FIRST_DIGIT;
      digitIndex_q <= 2'd3;
      frameTick_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      anode_q      <= anode_d;
      anodeDelay_q <= anodeDelay_d;
      digitIndex_q <= digitIndex_d;
      frameTick_q  <= frameTick_d;
    end
  end

  assign scan.anode      = anode_q;
  assign scan.anodeDelay = anodeDelay_q;
  assign scan.digitIndex = digitIndex_q;
  assign scan.frameTick  = frameTick_q;

endmodule

// File: tb/tb_anode_scan_ctrl.sv
// Self-checking bench for anode_scan_ctrl: one instance with B=2,S=3 and one with B=1,S=1.
// A directed vector table covers reset and a full frame; hand-written sequences cover enable drop, mid-show reset, minimum parameters and a random-enable soak.
module tb_anode_scan_ctrl;

  logic clk;
  logic rstA;
  logic rstB;
  int   checks;
  int   errors;

  anode_scan_ctrl_if ifA ();
  anode_scan_ctrl_if ifB ();

  anode_scan_ctrl #(.BLANK_CYCLES(2), .SHOW_CYCLES(3)) dutA (
    .clk   (clk),
    .reset (rstA),
    .scan  (ifA)
  );

  anode_scan_ctrl #(.BLANK_CYCLES(1), .SHOW_CYCLES(1)) dutB (
    .clk   (clk),
    .reset (rstB),
    .scan  (ifB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       en;
    logic [3:0] anode;
    logic [3:0] delay;
    logic [1:0] idx;
    logic       tick;
  } vec_t;

  // Reset for three cycles, then one full frame plus two cycles with B=2, S=3.
  vec_t tbl [0:24] = '{
    '{1'b1, 1'b1, 4'b1111, 4'b0111, 2'd3, 1'b0},
    '{1'b1, 1'b1, 4'b1111, 4'b0111, 2'd3, 1'b0},
    '{1'b1, 1'b1, 4'b1111, 4'b0111, 2'd3, 1'b0},
    '{1'b0, 1'b1, 4'b1111, 4'b0111, 2'd3, 1'b0},
    '{1'b0, 1'b1, 4'b0111, 4'b0111, 2'd3, 1'b0},
    '{1'b0, 1'b1, 4'b0111, 4'b0111, 2'd3, 1'b0},
    '{1'b0, 1'b1, 4'b0111, 4'b0111, 2'd3, 1'b0},
    '{1'b0, 1'b1, 4'b1111, 4'b1011, 2'd2, 1'b0},
    '{1'b0, 1'b1, 4'b1111, 4'b1011, 2'd2, 1'b0},
    '{1'b0, 1'b1, 4'b1011, 4'b1011, 2'd2, 1'b0},
    '{1'b0, 1'b1, 4'b1011, 4'b1011, 2'd2, 1'b0},
    '{1'b0, 1'b1, 4'b1011, 4'b1011, 2'd2, 1'b0},
    '{1'b0, 1'b1, 4'b1111, 4'b1101, 2'd1, 1'b0},
    '{1'b0, 1'b1, 4'b1111, 4'b1101, 2'd1, 1'b0},
    '{1'b0, 1'b1, 4'b1101, 4'b1101, 2'd1, 1'b0},
    '{1'b0, 1'b1, 4'b1101, 4'b1101, 2'd1, 1'b0},
    '{1'b0, 1'b1, 4'b1101, 4'b1101, 2'd1, 1'b0},
    '{1'b0, 1'b1, 4'b1111, 4'b1110, 2'd0, 1'b0},
    '{1'b0, 1'b1, 4'b1111, 4'b1110, 2'd0, 1'b0},
    '{1'b0, 1'b1, 4'b1110, 4'b1110, 2'd0, 1'b0},
    '{1'b0, 1'b1, 4'b1110, 4'b1110, 2'd0, 1'b0},
    '{1'b0, 1'b1, 4'b1110, 4'b1110, 2'd0, 1'b0},
    '{1'b0, 1'b1, 4'b1111, 4'b0111, 2'd3, 1'b1},
    '{1'b0, 1'b1, 4'b1111, 4'b0111, 2'd3, 1'b0},
    '{1'b0, 1'b1, 4'b0111, 4'b0111, 2'd3, 1'b0}
  };

  // Reference model of an uninterrupted scan, t = edges since reset release.
  function automatic logic [3:0] ringAt(int d);
    case (d % 4)
      0:       return 4'b0111;
      1:       return 4'b1011;
      2:       return 4'b1101;
      default: return 4'b1110;
    endcase
  endfunction

  function automatic logic [3:0] expDelay(int t, int b, int s);
    return ringAt(t / (b + s));
  endfunction

  function automatic logic [3:0] expAnode(int t, int b, int s);
    return ((t % (b + s)) < b) ? 4'b1111 : ringAt(t / (b + s));
  endfunction

  function automatic logic [1:0] expIdx(int t, int b, int s);
    return 2'(3 - ((t / (b + s)) % 4));
  endfunction

  function automatic logic expTick(int t, int b, int s);
    return (t > 0) && ((t % (4 * (b + s))) == 0);
  endfunction

  function automatic logic [1:0] idxOfDelay(logic [3:0] d);
    case (d)
      4'b0111: return 2'd3;
      4'b1011: return 2'd2;
      4'b1101: return 2'd1;
      default: return 2'd0;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic rA, input logic eA, input logic rB, input logic eB);
    rstA       = rA;
    ifA.enable = eA;
    rstB       = rB;
    ifB.enable = eB;
    @(posedge clk);
    #1;
  endtask

  task automatic checkA(input string tag, input logic [3:0] a, input logic [3:0] d,
                        input logic [1:0] i, input logic k);
    checkOutput({tag, ".anode"}, ifA.anode, a);
    checkOutput({tag, ".delay"}, ifA.anodeDelay, d);
    checkOutput({tag, ".idx"}, {2'b00, ifA.digitIndex}, {2'b00, i});
    checkOutput({tag, ".tick"}, {3'b000, ifA.frameTick}, {3'b000, k});
  endtask

  task automatic checkAModel(input string tag, input int t);
    checkA($sformatf("%s[t%0d]", tag, t), expAnode(t, 2, 3), expDelay(t, 2, 3),
           expIdx(t, 2, 3), expTick(t, 2, 3));
  endtask

  initial begin
    int lastTick;
    checks = 0;
    errors = 0;
    rstA = 1'b1;
    rstB = 1'b1;
    ifA.enable = 1'b1;
    ifB.enable = 1'b1;

    // Table: reset and normal scan.
    for (int i = 0; i < 25; i++) begin
      applyStimulus(tbl[i].rst, tbl[i].en, 1'b1, 1'b1);
      checkA($sformatf("tbl%0d", i), tbl[i].anode, tbl[i].delay, tbl[i].idx, tbl[i].tick);
    end

    // Enable drop during the second show cycle of digit 1011.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    for (int t = 1; t <= 8; t++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
      checkAModel("pre_drop", t);
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
      checkA($sformatf("drop%0d", i), 4'b1111, 4'b1011, 2'd2, 1'b0);
    end
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    checkA("resume0", 4'b1111, 4'b1011, 2'd2, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
      checkA($sformatf("resume%0d", i), 4'b1011, 4'b1011, 2'd2, 1'b0);
    end
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    checkA("resume4", 4'b1111, 4'b1101, 2'd1, 1'b0);

    // Reset while 1101 is lit, then the scan restarts from the top.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    for (int t = 1; t <= 12; t++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
      if (t == 12) checkOutput("pre_rst.anode", ifA.anode, 4'b1101);
    end
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    checkA("mid_rst", 4'b1111, 4'b0111, 2'd3, 1'b0);
    for (int t = 1; t <= 6; t++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
      checkAModel("post_rst", t);
    end

    // Minimum parameters on the second instance.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    lastTick = -1;
    for (int t = 1; t <= 20; t++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
      checkOutput($sformatf("min[t%0d].anode", t), ifB.anode, expAnode(t, 1, 1));
      checkOutput($sformatf("min[t%0d].delay", t), ifB.anodeDelay, expDelay(t, 1, 1));
      checkOutput($sformatf("min[t%0d].tick", t), {3'b000, ifB.frameTick},
                  {3'b000, expTick(t, 1, 1)});
      if (ifB.frameTick) begin
        if (lastTick >= 0)
          checkOutput("min.tick_period", 4'(t - lastTick), 4'd8);
        lastTick = t;
      end
    end

    // Random enable soak checking the structural invariants.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    for (int c = 0; c < 10000; c++) begin
      logic okAnode;
      logic okRing;
      applyStimulus(1'b0, ($urandom_range(0, 7) != 0), 1'b1, 1'b1);
      okAnode = (ifA.anode == 4'b1111) || (ifA.anode == ifA.anodeDelay);
      okRing  = (ifA.anodeDelay == 4'b0111) || (ifA.anodeDelay == 4'b1011) ||
                (ifA.anodeDelay == 4'b1101) || (ifA.anodeDelay == 4'b1110);
      checkOutput($sformatf("soak%0d.anode_ok", c), {3'b000, okAnode}, 4'd1);
      checkOutput($sformatf("soak%0d.onehot", c), {3'b000, okRing}, 4'd1);
      checkOutput($sformatf("soak%0d.idx", c), {2'b00, ifA.digitIndex},
                  {2'b00, idxOfDelay(ifA.anodeDelay)});
      if (ifA.frameTick)
        checkOutput($sformatf("soak%0d.tick_delay", c), ifA.anodeDelay, 4'b0111);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
